// File: rtl/perf_csr_reader_pkg.sv
// Shared constants and types for the I-cache performance CSR reader.
// Register addresses, widths and the bus FSM state encoding.
package perf_pkg;

    localparam int DW = 32;
    localparam int CW = 64;
    localparam int AW = 4;

    localparam logic [AW-1:0] A_ACC_LO   = 4'd0;
    localparam logic [AW-1:0] A_ACC_HI   = 4'd1;
    localparam logic [AW-1:0] A_MISS_LO  = 4'd2;
    localparam logic [AW-1:0] A_MISS_HI  = 4'd3;
    localparam logic [AW-1:0] A_CYC_LO   = 4'd4;
    localparam logic [AW-1:0] A_CYC_HI   = 4'd5;
    localparam logic [AW-1:0] A_WIN_CFG  = 4'd6;
    localparam logic [AW-1:0] A_WIN_MISS = 4'd7;
    localparam logic [AW-1:0] A_STATUS   = 4'd8;

    typedef enum logic {
        S_IDLE,
        S_RESP
    } bus_state_e;

endpackage

// File: rtl/perf_csr_reader_if.sv
// Request/ack register bus between a master and the perf CSR reader.
// ack is a one-cycle strobe; rdata is meaningful only alongside it.
interface perf_csr_if;
    import perf_pkg::*;

    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ack, rdata
    );

endinterface

// File: rtl/perf_csr_reader_window.sv
// Periodic miss-rate window: counts misses over WIN_CFG cycles.
// The delta is taken modulo 2^64 and saturated to 32 bits.
module perf_window
    import perf_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] miss,
    input  logic          cfg_wr,
    input  logic [DW-1:0] cfg_wdata,
    output logic [DW-1:0] cfg,
    output logic [DW-1:0] win_miss,
    output logic          win_valid
);

    logic [DW-1:0] cnt;
    logic [CW-1:0] miss_base;
    logic [CW-1:0] delta;
    logic [DW-1:0] delta_sat;
    logic          running;
    logic          expire;

    assign running   = (cfg != '0);
    assign expire    = running && (cnt == '0);
    assign delta     = miss - miss_base;
    assign delta_sat = (delta[CW-1:DW] != '0) ? '1 : delta[DW-1:0];

    // A config write takes priority over a coincident expiry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg       <= '0;
            cnt       <= '0;
            miss_base <= '0;
            win_miss  <= '0;
            win_valid <= 1'b0;
        end else if (cfg_wr) begin
            cfg       <= cfg_wdata;
            cnt       <= (cfg_wdata == '0) ? '0 : cfg_wdata - 1'b1;
            miss_base <= miss;
            win_valid <= 1'b0;
        end else if (expire) begin
            cnt       <= cfg - 1'b1;
            miss_base <= miss;
            win_miss  <= delta_sat;
            win_valid <= 1'b1;
        end else if (running) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/perf_csr_reader.sv
// CSR front end for the I-cache perf counters: coherent 192-bit
// snapshot on ACC_LO read, free-running cycle count, miss window.
module perf_csr_reader
    import perf_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] L1I_access,
    input  logic [CW-1:0] L1I_miss,
    perf_csr_if.slave     bus
);

    bus_state_e    state;
    bus_state_e    state_nxt;
    logic          take;
    logic          rd_en;
    logic          cfg_wr;
    logic          snap_cap;
    logic [CW-1:0] cyc;
    logic [CW-1:0] snap_acc;
    logic [CW-1:0] snap_miss;
    logic [CW-1:0] snap_cyc;
    logic          snap_valid;
    logic [DW-1:0] cfg;
    logic [DW-1:0] win_miss;
    logic          win_valid;
    logic [DW-1:0] rd_nxt;
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.req) state_nxt = S_RESP;
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign take     = (state == S_IDLE) && bus.req;
    assign rd_en    = take && !bus.we;
    assign cfg_wr   = take && bus.we && (bus.addr == A_WIN_CFG);
    assign snap_cap = rd_en && (bus.addr == A_ACC_LO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_acc   <= '0;
            snap_miss  <= '0;
            snap_cyc   <= '0;
            snap_valid <= 1'b0;
        end else if (snap_cap) begin
            snap_acc   <= L1I_access;
            snap_miss  <= L1I_miss;
            snap_cyc   <= cyc;
            snap_valid <= 1'b1;
        end
    end

    perf_window u_window (
        .clk       (clk),
        .rst       (rst),
        .miss      (L1I_miss),
        .cfg_wr    (cfg_wr),
        .cfg_wdata (bus.wdata),
        .cfg       (cfg),
        .win_miss  (win_miss),
        .win_valid (win_valid)
    );

    // ACC_LO returns the word being captured at this same edge.
    always_comb begin
        rd_nxt = '0;
        case (bus.addr)
            A_ACC_LO:   rd_nxt = L1I_access[DW-1:0];
            A_ACC_HI:   rd_nxt = snap_acc[CW-1:DW];
            A_MISS_LO:  rd_nxt = snap_miss[DW-1:0];
            A_MISS_HI:  rd_nxt = snap_miss[CW-1:DW];
            A_CYC_LO:   rd_nxt = snap_cyc[DW-1:0];
            A_CYC_HI:   rd_nxt = snap_cyc[CW-1:DW];
            A_WIN_CFG:  rd_nxt = cfg;
            A_WIN_MISS: rd_nxt = win_miss;
            A_STATUS:   rd_nxt = {30'd0, snap_valid, win_valid};
            default:    rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rdata_q <= '0;
        else if (take)  rdata_q <= rd_en ? rd_nxt : '0;
    end

    assign bus.ack   = (state == S_RESP);
    assign bus.rdata = bus.ack ? rdata_q : '0;

endmodule

// File: tb/tb_perf_csr_reader.sv
// Directed bench for perf_csr_reader: snapshot, window, saturation,
// handshake, write/expiry collision and reset during a response.
module tb_perf_csr_reader;
    import perf_pkg::*;

    logic          clk;
    logic          rst;
    logic [CW-1:0] L1I_access;
    logic [CW-1:0] L1I_miss;
    logic [CW-1:0] cyc_m;
    logic [CW-1:0] req_cyc;
    logic [CW-1:0] snap_cyc_exp;
    int            n_chk;
    int            n_err;

    perf_csr_if bus ();

    perf_csr_reader dut (
        .clk        (clk),
        .rst        (rst),
        .L1I_access (L1I_access),
        .L1I_miss   (L1I_miss),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc_m <= '0;
        else     cyc_m <= cyc_m + 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called 1ns after a rising edge with the FSM idle.
    task automatic xfer(input logic w, input logic [3:0] a,
                        input logic [31:0] d, output logic [31:0] rd);
        bus.req   = 1'b1;
        bus.we    = w;
        bus.addr  = a;
        bus.wdata = d;
        req_cyc   = cyc_m;
        tick(1);
        check("ack_hi", bus.ack, 1);
        rd        = bus.rdata;
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        tick(1);
        check("ack_lo", bus.ack, 0);
    endtask

    task automatic rd_chk(input string tag, input logic [3:0] a,
                          input logic [31:0] exp);
        logic [31:0] r;
        xfer(1'b0, a, 32'd0, r);
        check(tag, r, exp);
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] r;
        xfer(1'b1, a, d, r);
        check("wr_rdata", r, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk      = 0;
        n_err      = 0;
        clk        = 1'b0;
        rst        = 1'b1;
        bus.req    = 1'b0;
        bus.we     = 1'b0;
        bus.addr   = '0;
        bus.wdata  = '0;
        L1I_access = 64'h0000_0005_0000_0009;
        L1I_miss   = 64'h0000_0002_0000_0003;
        req_cyc    = '0;
        #22;
        check("rst_ack", bus.ack, 0);
        check("rst_rdata", bus.rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);

        // Nothing captured yet
        rd_chk("pre_acc_hi", A_ACC_HI, 0);
        rd_chk("pre_cyc_lo", A_CYC_LO, 0);
        rd_chk("pre_status", A_STATUS, 0);

        // Snapshot coherence
        L1I_access = 64'h0000_0001_FFFF_FFFF;
        L1I_miss   = 64'h0000_0003_0000_0007;
        rd_chk("acc_lo", A_ACC_LO, 32'hFFFF_FFFF);
        snap_cyc_exp = req_cyc;
        L1I_access = 64'h0000_0002_0000_0000;
        L1I_miss   = 64'h0000_0009_0000_0009;
        rd_chk("acc_hi", A_ACC_HI, 32'h1);
        rd_chk("miss_lo", A_MISS_LO, 32'h7);
        rd_chk("miss_hi", A_MISS_HI, 32'h3);
        rd_chk("cyc_lo", A_CYC_LO, snap_cyc_exp[31:0]);
        rd_chk("cyc_hi", A_CYC_HI, snap_cyc_exp[63:32]);
        rd_chk("status_snap", A_STATUS, 32'h2);

        // Writes to read-only registers are ignored
        wr(A_ACC_LO, 32'hDEAD_BEEF);
        rd_chk("ro_acc_hi", A_ACC_HI, 32'h1);
        wr(A_WIN_MISS, 32'h1234_5678);
        rd_chk("ro_win_miss", A_WIN_MISS, 0);

        // Window of 4 with three misses
        L1I_miss = 64'd100;
        wr(A_WIN_CFG, 32'd4);
        L1I_miss = 64'd101;
        tick(1);
        L1I_miss = 64'd102;
        tick(1);
        L1I_miss = 64'd103;
        tick(1);
        rd_chk("win_miss", A_WIN_MISS, 32'd3);
        rd_chk("status_win", A_STATUS, 32'h3);
        rd_chk("win_cfg", A_WIN_CFG, 32'd4);

        // Saturating delta
        wr(A_WIN_CFG, 32'd4);
        L1I_miss = 64'd103 + (64'd1 << 33);
        tick(3);
        rd_chk("win_sat", A_WIN_MISS, 32'hFFFF_FFFF);

        // Config write on the expiry edge wins
        wr(A_WIN_CFG, 32'd4);
        L1I_miss = L1I_miss + 64'd5;
        tick(2);
        wr(A_WIN_CFG, 32'd0);
        rd_chk("col_win_miss", A_WIN_MISS, 32'hFFFF_FFFF);
        rd_chk("col_status", A_STATUS, 32'h2);
        rd_chk("col_cfg", A_WIN_CFG, 32'd0);

        // req held three cycles
        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = 4'd12;
        check("hs_c1", bus.ack, 0);
        tick(1);
        check("hs_c2", bus.ack, 1);
        check("hs_c2_rdata", bus.rdata, 0);
        tick(1);
        check("hs_c3", bus.ack, 0);
        tick(1);
        bus.req = 1'b0;
        check("hs_c4", bus.ack, 1);
        check("hs_c4_rdata", bus.rdata, 0);
        tick(1);
        check("hs_c5", bus.ack, 0);

        // Reset while responding
        wr(A_WIN_CFG, 32'd7);
        bus.req  = 1'b1;
        bus.addr = A_STATUS;
        tick(1);
        check("rr_ack_pre", bus.ack, 1);
        check("rr_rdata_pre", bus.rdata, 32'h2);
        bus.req = 1'b0;
        rst     = 1'b1;
        #1;
        check("rr_ack", bus.ack, 0);
        check("rr_rdata", bus.rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        tick(1);
        for (int a = 1; a <= 8; a++)
            rd_chk($sformatf("post_rst_%0d", a), 4'(a), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/perf_csr_reader.md
PERF_CSR_READER -- requirements
Module: perf_csr_reader

Interface
REQ-001 The block SHALL have clk input 1 as its clock; all state updates on the rising edge.
REQ-002 The block SHALL have rst input 1, reset, asynchronous, active-high.
REQ-003 The block SHALL have L1I_access input 64, the running I-cache access count from the I-cache performance counter.
REQ-004 The block SHALL have L1I_miss input 64, the running I-cache miss count from the same counter.
REQ-005 The block SHALL have req input 1, bus request, held high until ack.
REQ-006 The block SHALL have we input 1, write enable, qualified by req.
REQ-007 The block SHALL have addr input 4, word address.
REQ-008 The block SHALL have wdata input 32, write data.
REQ-009 The block SHALL have ack output 1, one-cycle response strobe.
REQ-010 The block SHALL have rdata output 32, read data, valid only while ack=1, else 0.

Function
REQ-011 Register map SHALL be: 0 ACC_LO, 1 ACC_HI, 2 MISS_LO, 3 MISS_HI, 4 CYC_LO, 5 CYC_HI, 6 WIN_CFG (RW), 7 WIN_MISS, 8 STATUS {bit1 snap_valid, bit0 win_valid}, 9-15 unmapped.
REQ-012 A free-running 64-bit cycle counter SHALL increment every cycle, wrapping modulo 2^64.
REQ-013 Bus FSM SHALL have states IDLE and RESP: IDLE with req=1 -> RESP; RESP -> IDLE unconditionally; ack=1 exactly in RESP.
REQ-014 Latency SHALL be one cycle: req sampled at edge N, ack and rdata valid for the cycle after edge N.
REQ-015 Request sampled in RESP SHALL be ignored; a master still holding req after ack starts a new transaction on the next IDLE edge.
REQ-016 A read of ACC_LO SHALL capture L1I_access, L1I_miss and the cycle counter into a 192-bit snapshot at the sampling edge and set snap_valid.
REQ-017 Reads of addresses 0-5 SHALL return the snapshot halves; ACC_LO returns the newly captured low word.
REQ-018 Before the first snapshot, addresses 1-5 SHALL return 0.
REQ-019 Writes to read-only or unmapped addresses SHALL be acked and ignored; reads of unmapped addresses SHALL return 0 with ack.
REQ-020 WIN_CFG=0 SHALL stop the window; nonzero W SHALL run a down-counter loaded with W-1, expiring every W cycles.
REQ-021 On expiry SHALL occur: WIN_MISS <= (L1I_miss - miss_base) computed modulo 2^64, saturated to 32'hFFFF_FFFF; miss_base <= L1I_miss; win_valid <= 1; counter reloads.
REQ-022 A write to WIN_CFG SHALL take effect at the sampling edge: load the new value, set miss_base <= L1I_miss, reload the counter, and clear win_valid.
REQ-023 When a WIN_CFG write and an expiry coincide, the write SHALL win and WIN_MISS SHALL be unchanged.
REQ-024 A read of WIN_MISS SHALL NOT clear win_valid.

Reset
REQ-025 rst SHALL force: FSM to IDLE; ack, rdata, snapshot, cycle counter, WIN_CFG, WIN_MISS, miss_base, down-counter, snap_valid and win_valid all to 0.
REQ-026 rst asserted during RESP SHALL drop ack immediately, and the transaction SHALL be lost.

Structure
REQ-027 Package perf_pkg SHALL hold the address localparams, the bus FSM state enum and the 32/64-bit width constants.
REQ-028 Sub-module perf_window SHALL contain the down-counter, miss_base, saturating delta, and the WIN_MISS and win_valid registers.

Verification
REQ-029 Bench SHALL cover snapshot coherence: L1I_access=64'h1_FFFF_FFFF, read addr 0 -> rdata=FFFF_FFFF; then inputs change to 64'h2_0000_0000, read addr 1 -> rdata=1.
REQ-030 Bench SHALL cover windowing: WIN_CFG=4, miss increments 3 times in the window -> after 4 cycles WIN_MISS=3 and STATUS=2'bx1.
REQ-031 Bench SHALL cover saturation: miss delta of 2^33 within one window -> WIN_MISS=FFFF_FFFF.
REQ-032 Bench SHALL cover the handshake: req held 3 cycles -> ack on cycles 2 and 4 only; read addr 12 -> ack=1 with rdata=0.
REQ-033 Bench SHALL cover collision: a WIN_CFG write on the expiry cycle -> WIN_MISS unchanged and win_valid=0.
REQ-034 Bench SHALL cover reset: rst asserted in RESP -> ack=0 in the same cycle, and all registers read 0 afterward.
